// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: opcodes, the dispatcher
// state type, the queued command format and the supported-opcode test.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_LLS = 4'd8;
  localparam logic [3:0] OP_LRS = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
  } alu_cmd_t;

  // Opcodes 12..15 and NOP never reach the ALU.
  function automatic logic is_supported_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue between the handshake input and the dispatcher FSM.
// Push is ignored when full, pop is ignored when empty; the head entry is
// presented combinationally so the FSM can pop and decode in one cycle.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  alu_cmd_t                   wr_data_i,
  input  logic                       pop_i,
  output alu_cmd_t                   head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  alu_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Issues queued ALU commands one at a time, holds the ALU inputs for the
// pipeline depth plus one, captures the result and returns it in order.
//
//   state | meaning
//   IDLE  | waiting for a queued command; pops the head when one exists
//   ISSUE | ALU inputs driven, counter running down to the capture edge
//   RESP  | response held on rsp_* until the consumer accepts it
module alu_cmd_dispatcher
  import alu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [3:0]  alu_opcode,
  output logic [15:0] alu_operand_a,
  output logic [15:0] alu_operand_b,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_opcode,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CNTW = $clog2(ALU_LATENCY + 2);

  disp_state_e                state_q;
  logic [CNTW-1:0]            cnt_q;
  logic [3:0]                 iss_op_q;
  logic [3:0]                 alu_op_q;
  logic [15:0]                alu_a_q;
  logic [15:0]                alu_b_q;
  logic                       rsp_valid_q;
  logic [31:0]                rsp_result_q;
  logic [3:0]                 rsp_opcode_q;
  logic                       rsp_err_q;

  alu_cmd_t                   head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       pop_en;

  assign pop_en = (state_q == IDLE) && !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (cmd_valid),
    .wr_data_i ('{opcode: cmd_opcode, a: cmd_a, b: cmd_b}),
    .pop_i     (pop_en),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Ready comes from the registered count only; a same-cycle pop does not
  // open a slot early.
  assign cmd_ready     = !fifo_full;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);
  assign alu_opcode    = alu_op_q;
  assign alu_operand_a = alu_a_q;
  assign alu_operand_b = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_opcode    = rsp_opcode_q;
  assign rsp_err       = rsp_err_q;

  // Dispatcher FSM with registered ALU and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      iss_op_q     <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            iss_op_q <= head.opcode;
            if (is_supported_op(head.opcode)) begin
              alu_op_q <= head.opcode;
              alu_a_q  <= head.a;
              alu_b_q  <= head.b;
              cnt_q    <= CNTW'(ALU_LATENCY + 1);
              state_q  <= ISSUE;
            end else begin
              // Unsupported opcodes bypass the ALU entirely.
              rsp_result_q <= '0;
              rsp_opcode_q <= head.opcode;
              rsp_err_q    <= 1'b1;
              rsp_valid_q  <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == CNTW'(1)) begin
            rsp_result_q <= alu_result;
            rsp_opcode_q <= iss_op_q;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            cnt_q        <= '0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_dispatcher.md
# alu_cmd_dispatcher

Command front end for the 16-bit ALU. Accepts operation commands (opcode, two operands) over a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time to the ALU. It holds each command's ALU inputs stable for the ALU pipeline depth, then captures the 32-bit result and returns it over a second valid/ready handshake. Commands complete strictly in order.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- ALU_LATENCY, 2, number of ALU clock edges from stable inputs to valid `result`

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH), from registered count only
- cmd_opcode  in  4  ALU opcode
- cmd_a  in  16  operand A
- cmd_b  in  16  operand B
- alu_opcode  out  4  to ALU opcode
- alu_operand_a  out  16  to ALU operandA
- alu_operand_b  out  16  to ALU operandB
- alu_result  in  32  from ALU result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_opcode  out  4  opcode of the response's command
- rsp_err  out  1  opcode was unsupported; result forced to 0
- busy  out  1  state ≠ IDLE or count ≠ 0

## Operation
- Push: on cmd_valid && cmd_ready, write {opcode, a, b} at wr_ptr, then increment wr_ptr (wraps at DEPTH) and count.
- Supported opcodes are 1..11 (ADD, SUB, MUL, DIV, AND, OR, XOR, LLS, LRS, INC, DEC). 0 and 12..15 are unsupported.
- FSM:
  - IDLE: if count > 0, pop the head entry into the issue register. Go to ISSUE if the opcode is supported; otherwise go to RESP with result 0 and err 1.
  - ISSUE: drive the alu_* outputs from the issue register. Load the counter with ALU_LATENCY+1 on entry and decrement it each cycle. At the edge where the counter equals 1, capture alu_result into rsp_result with err 0, then go to RESP.
  - RESP: rsp_valid = 1. On rsp_ready, go to IDLE.
- In all states other than ISSUE, alu_opcode, alu_operand_a and alu_operand_b are 0 (ALU NOP).
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- When the FIFO is full, cmd_ready is 0 even if a pop occurs in that cycle. No bypass.
- rsp_result, rsp_opcode and rsp_err stay stable from the cycle rsp_valid rises until the handshake completes.

## Timing
- Reset values: cmd_ready 1, rsp_valid 0, rsp_result 0, rsp_opcode 0, rsp_err 0, all alu_* outputs 0, busy 0. Pointers, count and counter are 0; state is IDLE.
- Reset mid-operation: the FIFO is flushed and any in-flight command is discarded. No response is produced for it after reset is released.
- Supported command, empty block: accept edge E0 → pop at E1 → alu_* driven for 3 cycles → capture at E4. rsp_valid is high after E4, i.e. latency is ALU_LATENCY+2 edges.
- Unsupported command: rsp_valid is high after E1. The alu_* outputs never leave 0.
- Throughput: at least ALU_LATENCY+3 cycles per supported command (IDLE, ISSUE, RESP).
- Capacity while a response is stalled: 1 in RESP plus DEPTH queued.

## Structure
- Shared package `alu_pkg` contains:
  - opcode localparams OP_NOP=0 through OP_DEC=11
  - function `is_supported_op`
  - dispatcher state enum {IDLE, ISSUE, RESP}
  - command struct {opcode, a, b}
- Sub-module `alu_cmd_fifo` is the parameterised synchronous FIFO with pointers, count, full and empty. The FSM, issue register and response register live in `alu_cmd_dispatcher`.

## Test plan
1. Reset, then push {ADD,10,5} with rsp_ready=1 → alu_opcode=1, a=10, b=5 for exactly 3 cycles; rsp_valid after E4 with rsp_result=15, rsp_opcode=1, err=0.
2. Push {SUB,15,7}, {MUL,10,3}, {INC,45,0} back-to-back → responses in order: 8, 30, 46. alu_opcode is 0 in every cycle between commands.
3. rsp_ready=0, push 6 commands back-to-back → exactly 5 accepted, then cmd_ready=0. Raising rsp_ready drains all 5 in order.
4. Push opcode 4'b1111 → rsp_valid one edge after pop, result 0, err 1; alu_opcode stays 0.
5. Hold rsp_ready=0 for 10 cycles during a response → rsp_result, rsp_opcode and rsp_err are stable, and no ALU issue occurs.
6. Assert reset_n low during ISSUE of {DIV,25,5} → all outputs go to reset values immediately; after release, no response appears and cmd_ready=1.
